// File: rtl/decode_stage.sv
// ID stage of the mini-rv RV32I pipeline: register file, immediate/control decode,
// load-use hazard detection and the ID/EX pipeline register.
module decode_stage #(
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if_id_instr_data,
    input  logic [31:0] if_id_pc,
    input  logic        ex_if_branch_taken,
    input  logic        wb_id_we,
    input  logic [4:0]  wb_id_rd,
    input  logic [31:0] wb_id_wdata,
    output logic        stall,
    output logic        id_ex_valid,
    output logic [31:0] id_ex_pc,
    output logic [31:0] id_ex_rs1_data,
    output logic [31:0] id_ex_rs2_data,
    output logic [31:0] id_ex_imm,
    output logic [4:0]  id_ex_rs1,
    output logic [4:0]  id_ex_rs2,
    output logic [4:0]  id_ex_rd,
    output logic [2:0]  id_ex_funct3,
    output logic        id_ex_funct7_b5,
    output logic [6:0]  id_ex_opcode,
    output logic        id_ex_alu_src,
    output logic        id_ex_mem_read,
    output logic        id_ex_mem_write,
    output logic        id_ex_reg_write,
    output logic        id_ex_branch,
    output logic        id_ex_jump,
    output logic        id_ex_illegal
);
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpReg    = 7'b0110011;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpJal    = 7'b1101111;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic        funct7_b5;
        logic [6:0]  opcode;
        logic        alu_src;
        logic        mem_read;
        logic        mem_write;
        logic        reg_write;
        logic        branch;
        logic        jump;
        logic        illegal;
    } id_ex_t;

    logic [31:0] rf_q [32];
    id_ex_t      dec, id_ex_d, id_ex_q;
    logic        uses_rs1, uses_rs2, hazard;
    logic [31:0] instr, rs1_data, rs2_data;
    logic [4:0]  rs1, rs2;

    assign instr = if_id_instr_data;
    assign rs1   = instr[19:15];
    assign rs2   = instr[24:20];

    // Write-through lets writeback and decode of a dependent instruction share a cycle.
    assign rs1_data = (rs1 == 5'd0) ? 32'd0 :
                      (wb_id_we && wb_id_rd == rs1) ? wb_id_wdata : rf_q[rs1];
    assign rs2_data = (rs2 == 5'd0) ? 32'd0 :
                      (wb_id_we && wb_id_rd == rs2) ? wb_id_wdata : rf_q[rs2];

    always_comb begin
        dec           = '0;
        uses_rs1      = 1'b0;
        uses_rs2      = 1'b0;
        dec.valid     = 1'b1;
        dec.pc        = if_id_pc;
        dec.rs1_data  = rs1_data;
        dec.rs2_data  = rs2_data;
        dec.rs1       = rs1;
        dec.rs2       = rs2;
        dec.rd        = instr[11:7];
        dec.funct3    = instr[14:12];
        dec.funct7_b5 = instr[30];
        dec.opcode    = instr[6:0];
        case (instr[6:0])
            OpReg: begin
                dec.reg_write = 1'b1;
                uses_rs1      = 1'b1;
                uses_rs2      = 1'b1;
            end
            OpImm, OpLoad, OpJalr: begin
                dec.imm       = {{20{instr[31]}}, instr[31:20]};
                dec.alu_src   = 1'b1;
                dec.reg_write = 1'b1;
                dec.mem_read  = (instr[6:0] == OpLoad);
                dec.jump      = (instr[6:0] == OpJalr);
                uses_rs1      = 1'b1;
            end
            OpStore: begin
                dec.imm       = {{20{instr[31]}}, instr[31:25], instr[11:7]};
                dec.alu_src   = 1'b1;
                dec.mem_write = 1'b1;
                uses_rs1      = 1'b1;
                uses_rs2      = 1'b1;
            end
            OpBranch: begin
                dec.imm    = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                              instr[11:8], 1'b0};
                dec.branch = 1'b1;
                uses_rs1   = 1'b1;
                uses_rs2   = 1'b1;
            end
            OpLui, OpAuipc: begin
                dec.imm       = {instr[31:12], 12'b0};
                dec.alu_src   = 1'b1;
                dec.reg_write = 1'b1;
            end
            OpJal: begin
                dec.imm       = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                                 instr[30:21], 1'b0};
                dec.alu_src   = 1'b1;
                dec.reg_write = 1'b1;
                dec.jump      = 1'b1;
            end
            default: dec.illegal = 1'b1;
        endcase
    end

    assign hazard = id_ex_q.valid && id_ex_q.mem_read && (id_ex_q.rd != 5'd0) &&
                    ((uses_rs1 && rs1 == id_ex_q.rd) || (uses_rs2 && rs2 == id_ex_q.rd));
    assign stall  = hazard && !ex_if_branch_taken;

    // Flush and load-use stall both insert a bubble; they differ only in the stall output.
    always_comb begin
        id_ex_d = dec;
        if (ex_if_branch_taken || hazard) begin
            id_ex_d.valid     = 1'b0;
            id_ex_d.alu_src   = 1'b0;
            id_ex_d.mem_read  = 1'b0;
            id_ex_d.mem_write = 1'b0;
            id_ex_d.reg_write = 1'b0;
            id_ex_d.branch    = 1'b0;
            id_ex_d.jump      = 1'b0;
            id_ex_d.illegal   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            id_ex_q    <= '0;
            id_ex_q.pc <= RESET_PC;
            for (int i = 0; i < 32; i++) begin
                rf_q[i] <= 32'd0;
            end
        end else begin
            id_ex_q <= id_ex_d;
            if (wb_id_we && wb_id_rd != 5'd0) begin
                rf_q[wb_id_rd] <= wb_id_wdata;
            end
        end
    end

    assign id_ex_valid     = id_ex_q.valid;
    assign id_ex_pc        = id_ex_q.pc;
    assign id_ex_rs1_data  = id_ex_q.rs1_data;
    assign id_ex_rs2_data  = id_ex_q.rs2_data;
    assign id_ex_imm       = id_ex_q.imm;
    assign id_ex_rs1       = id_ex_q.rs1;
    assign id_ex_rs2       = id_ex_q.rs2;
    assign id_ex_rd        = id_ex_q.rd;
    assign id_ex_funct3    = id_ex_q.funct3;
    assign id_ex_funct7_b5 = id_ex_q.funct7_b5;
    assign id_ex_opcode    = id_ex_q.opcode;
    assign id_ex_alu_src   = id_ex_q.alu_src;
    assign id_ex_mem_read  = id_ex_q.mem_read;
    assign id_ex_mem_write = id_ex_q.mem_write;
    assign id_ex_reg_write = id_ex_q.reg_write;
    assign id_ex_branch    = id_ex_q.branch;
    assign id_ex_jump      = id_ex_q.jump;
    assign id_ex_illegal   = id_ex_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: a behavioural ISA-level model predicts stall and the
// ID/EX contents every cycle; literal checks pin the model on hand-decoded instructions.
module tb_decode_stage;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_id_instr_data, if_id_pc;
    logic        ex_if_branch_taken;
    logic        wb_id_we;
    logic [4:0]  wb_id_rd;
    logic [31:0] wb_id_wdata;
    logic        stall, id_ex_valid;
    logic [31:0] id_ex_pc, id_ex_rs1_data, id_ex_rs2_data, id_ex_imm;
    logic [4:0]  id_ex_rs1, id_ex_rs2, id_ex_rd;
    logic [2:0]  id_ex_funct3;
    logic        id_ex_funct7_b5;
    logic [6:0]  id_ex_opcode;
    logic        id_ex_alu_src, id_ex_mem_read, id_ex_mem_write, id_ex_reg_write;
    logic        id_ex_branch, id_ex_jump, id_ex_illegal;

    always #5 clk = ~clk;

    decode_stage #(.RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst),
        .if_id_instr_data(if_id_instr_data), .if_id_pc(if_id_pc),
        .ex_if_branch_taken(ex_if_branch_taken),
        .wb_id_we(wb_id_we), .wb_id_rd(wb_id_rd), .wb_id_wdata(wb_id_wdata),
        .stall(stall), .id_ex_valid(id_ex_valid), .id_ex_pc(id_ex_pc),
        .id_ex_rs1_data(id_ex_rs1_data), .id_ex_rs2_data(id_ex_rs2_data),
        .id_ex_imm(id_ex_imm), .id_ex_rs1(id_ex_rs1), .id_ex_rs2(id_ex_rs2),
        .id_ex_rd(id_ex_rd), .id_ex_funct3(id_ex_funct3),
        .id_ex_funct7_b5(id_ex_funct7_b5), .id_ex_opcode(id_ex_opcode),
        .id_ex_alu_src(id_ex_alu_src), .id_ex_mem_read(id_ex_mem_read),
        .id_ex_mem_write(id_ex_mem_write), .id_ex_reg_write(id_ex_reg_write),
        .id_ex_branch(id_ex_branch), .id_ex_jump(id_ex_jump),
        .id_ex_illegal(id_ex_illegal)
    );

    typedef struct {
        logic        valid;
        logic [31:0] pc, rs1_data, rs2_data, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [2:0]  f3;
        logic        f7;
        logic [6:0]  op;
        logic        alu_src, mem_read, mem_write, reg_write, branch, jump, illegal;
    } exp_t;

    logic [31:0] m_rf [32];
    logic        m_load_valid = 1'b0;
    logic [4:0]  m_load_rd = 5'd0;
    logic        stall_seen;
    int          n_vec = 0;
    int          n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int sx(input int v, input int bits);
        return (v >= (1 << (bits - 1))) ? v - (1 << bits) : v;
    endfunction

    function automatic logic [31:0] rd_reg(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (wb_id_we && wb_id_rd == a) return wb_id_wdata;
        return m_rf[a];
    endfunction

    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc,
                                   output bit u1, output bit u2);
        exp_t x;
        int   v;
        x = '{default: '0};
        x.valid = 1'b1; x.pc = pc; x.op = ins[6:0];
        x.rs1 = ins[19:15]; x.rs2 = ins[24:20]; x.rd = ins[11:7];
        x.f3 = ins[14:12]; x.f7 = ins[30];
        x.rs1_data = rd_reg(x.rs1);
        x.rs2_data = rd_reg(x.rs2);
        u1 = 1'b1; u2 = 1'b0;
        case (ins[6:0])
            7'h33: begin x.reg_write = 1; u2 = 1; end
            7'h13, 7'h03, 7'h67: begin
                x.imm = 32'(sx(int'(ins[31:20]), 12));
                x.alu_src = 1; x.reg_write = 1;
                x.mem_read = (ins[6:0] == 7'h03);
                x.jump = (ins[6:0] == 7'h67);
            end
            7'h23: begin
                x.imm = 32'(sx(int'(ins[31:25]) * 32 + int'(ins[11:7]), 12));
                x.alu_src = 1; x.mem_write = 1; u2 = 1;
            end
            7'h63: begin
                v = int'(ins[31]) * 4096 + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 +
                    int'(ins[11:8]) * 2;
                x.imm = 32'(sx(v, 13)); x.branch = 1; u2 = 1;
            end
            7'h37, 7'h17: begin
                x.imm = ins & 32'hFFFF_F000; x.alu_src = 1; x.reg_write = 1; u1 = 0;
            end
            7'h6F: begin
                v = int'(ins[31]) * (1 << 20) + int'(ins[19:12]) * 4096 +
                    int'(ins[20]) * 2048 + int'(ins[30:21]) * 2;
                x.imm = 32'(sx(v, 21)); x.alu_src = 1; x.reg_write = 1; x.jump = 1;
                u1 = 0;
            end
            default: begin x.illegal = 1; u1 = 0; end
        endcase
        return x;
    endfunction

    // One clock of stimulus with full model-vs-DUT comparison; inputs already driven.
    task automatic tick();
        exp_t e;
        bit   u1, u2, haz, stall_exp, full;
        #2;
        e = model(if_id_instr_data, if_id_pc, u1, u2);
        haz = m_load_valid && m_load_rd != 0 &&
              ((u1 && if_id_instr_data[19:15] == m_load_rd) ||
               (u2 && if_id_instr_data[24:20] == m_load_rd));
        stall_exp = haz && !ex_if_branch_taken;
        stall_seen = stall;
        if (!rst) chk("stall", {31'd0, stall}, {31'd0, stall_exp});
        full = 1'b1;
        if (rst) begin
            e = '{default: '0};
            e.pc = RESET_PC;
        end else if (ex_if_branch_taken || haz) begin
            e.valid = 0; e.alu_src = 0; e.mem_read = 0; e.mem_write = 0;
            e.reg_write = 0; e.branch = 0; e.jump = 0; e.illegal = 0;
            full = 1'b0;
        end
        @(posedge clk);
        #1;
        chk("valid", {31'd0, id_ex_valid}, {31'd0, e.valid});
        chk("ctrl", {25'd0, id_ex_alu_src, id_ex_mem_read, id_ex_mem_write, id_ex_reg_write,
                     id_ex_branch, id_ex_jump, id_ex_illegal},
            {25'd0, e.alu_src, e.mem_read, e.mem_write, e.reg_write, e.branch, e.jump,
             e.illegal});
        if (full) begin
            chk("pc", id_ex_pc, e.pc);
            chk("rs1_data", id_ex_rs1_data, e.rs1_data);
            chk("rs2_data", id_ex_rs2_data, e.rs2_data);
            chk("imm", id_ex_imm, e.imm);
            chk("regs", {17'd0, id_ex_rs1, id_ex_rs2, id_ex_rd},
                {17'd0, e.rs1, e.rs2, e.rd});
            chk("fields", {21'd0, id_ex_funct3, id_ex_funct7_b5, id_ex_opcode},
                {21'd0, e.f3, e.f7, e.op});
        end
        if (rst) begin
            for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
            m_load_valid = 1'b0;
        end else begin
            if (wb_id_we && wb_id_rd != 0) m_rf[wb_id_rd] = wb_id_wdata;
            m_load_valid = e.valid && e.mem_read;
            m_load_rd = e.rd;
        end
        @(negedge clk);
    endtask

    task automatic issue(input logic [31:0] ins, input logic [31:0] pc);
        if_id_instr_data = ins;
        if_id_pc = pc;
        tick();
    endtask

    initial begin
        rst = 1; ex_if_branch_taken = 0; wb_id_we = 0; wb_id_rd = 0; wb_id_wdata = 0;
        if_id_instr_data = 0; if_id_pc = 0;
        tick(); tick();
        chk("rst_valid", {31'd0, id_ex_valid}, 32'd0);
        chk("rst_pc", id_ex_pc, RESET_PC);
        rst = 0;
        issue(32'h0001_8233, 32'h0);
        chk("post_rst_stall", {31'd0, stall_seen}, 32'd0);
        chk("post_rst_x3", id_ex_rs1_data, 32'd0);

        issue(32'h0050_0093, 32'h10);
        chk("addi_valid", {31'd0, id_ex_valid}, 32'd1);
        chk("addi_imm", id_ex_imm, 32'd5);
        chk("addi_rd", {27'd0, id_ex_rd}, 32'd1);
        chk("addi_rs1", {27'd0, id_ex_rs1}, 32'd0);
        chk("addi_rw_src", {30'd0, id_ex_reg_write, id_ex_alu_src}, 32'd3);
        chk("addi_pc", id_ex_pc, 32'h10);

        wb_id_we = 1; wb_id_rd = 3; wb_id_wdata = 32'hDEAD_BEEF;
        issue(32'h0001_8233, 32'h14);
        chk("wthru_x3", id_ex_rs1_data, 32'hDEAD_BEEF);
        wb_id_rd = 0; wb_id_wdata = 32'h1234;
        issue(32'h0000_0233, 32'h18);
        chk("x0_zero", id_ex_rs1_data, 32'd0);
        wb_id_rd = 1; wb_id_wdata = 32'h100;
        issue(32'h0001_8233, 32'h1C);
        chk("x3_stored", id_ex_rs1_data, 32'hDEAD_BEEF);
        wb_id_rd = 2; wb_id_wdata = 32'h2222;
        issue(32'hFE20_AE23, 32'h20);  // sw x2,-4(x1)
        chk("sw_imm", id_ex_imm, 32'hFFFF_FFFC);
        chk("sw_data", id_ex_rs2_data, 32'h2222);
        wb_id_we = 0;
        issue(32'h1234_52B7, 32'h24);  // lui x5,0x12345
        chk("lui_imm", id_ex_imm, 32'h1234_5000);
        issue(32'h0000_1317, 32'h28);  // auipc x6,1
        issue(32'h0100_00EF, 32'h2C);  // jal x1,16
        chk("jal_imm", id_ex_imm, 32'd16);
        chk("jal_jump", {31'd0, id_ex_jump}, 32'd1);
        issue(32'h0000_8067, 32'h30);  // jalr x0,0(x1)
        issue(32'hFFF0_E393, 32'h34);  // ori x7,x1,-1
        chk("ori_imm", id_ex_imm, 32'hFFFF_FFFF);

        issue(32'h0000_A103, 32'h40);  // lw x2,0(x1)
        issue(32'h0021_01B3, 32'h44);  // add x3,x2,x2
        chk("lu_stall", {31'd0, stall_seen}, 32'd1);
        chk("lu_bubble", {30'd0, id_ex_valid, id_ex_reg_write}, 32'd0);
        issue(32'h0021_01B3, 32'h44);
        chk("lu_stall_once", {31'd0, stall_seen}, 32'd0);
        chk("lu_issue", {21'd0, id_ex_valid, id_ex_rs1, id_ex_rs2}, {21'd1, 5'd2, 5'd2});

        issue(32'h0000_A103, 32'h48);
        issue(32'h0052_81B3, 32'h4C);  // add x3,x5,x5
        chk("nodep_stall", {31'd0, stall_seen}, 32'd0);
        chk("nodep_valid", {31'd0, id_ex_valid}, 32'd1);

        issue(32'h0000_A103, 32'h50);
        ex_if_branch_taken = 1;
        issue(32'h0021_01B3, 32'h54);
        chk("flush_stall", {31'd0, stall_seen}, 32'd0);
        chk("flush_valid", {31'd0, id_ex_valid}, 32'd0);
        ex_if_branch_taken = 0;

        issue(32'hFE00_0CE3, 32'h60);  // beq x0,x0,-8
        chk("beq_imm", id_ex_imm, 32'hFFFF_FFF8);
        chk("beq_ctrl", {29'd0, id_ex_branch, id_ex_reg_write, id_ex_alu_src}, 32'd4);
        issue(32'h0000_007F, 32'h64);
        chk("ill_flag", {31'd0, id_ex_illegal}, 32'd1);
        chk("ill_ctrl", {26'd0, id_ex_alu_src, id_ex_mem_read, id_ex_mem_write,
                         id_ex_reg_write, id_ex_branch, id_ex_jump}, 32'd0);

        issue(32'h0000_A103, 32'h70);
        rst = 1; wb_id_we = 1; wb_id_rd = 5; wb_id_wdata = 32'h55;
        issue(32'h0021_01B3, 32'h74);
        chk("midrst_valid", {31'd0, id_ex_valid}, 32'd0);
        chk("midrst_pc", id_ex_pc, RESET_PC);
        rst = 0; wb_id_we = 0;
        issue(32'h0001_8233, 32'h0);
        chk("midrst_x3", id_ex_rs1_data, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
Instruction decode stage of the mini-rv 5-stage RV32I pipeline. It sits directly downstream of fetch and consumes the fetched instruction word and its PC. It contains the 32x32 register file (written by writeback), immediate generation, control decode, load-use hazard detection (drives the fetch stall), and the ID/EX pipeline register. It squashes the in-flight decode slot on a taken branch.

Parameters:
RESET_PC, 32'h0, value loaded into id_ex_pc on reset

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- if_id_instr_data  in  32  instruction word, aligned with if_id_pc
- if_id_pc  in  32  PC of instruction in decode
- ex_if_branch_taken  in  1  EX redirect; squashes decode slot
- wb_id_we  in  1  register-file write enable
- wb_id_rd  in  5  write address
- wb_id_wdata  in  32  write data
- stall  out  1  combinational; holds fetch (and this stage's input)
- id_ex_valid  out  1  ID/EX slot holds a real instruction
- id_ex_pc  out  32  PC
- id_ex_rs1_data, id_ex_rs2_data  out  32 each  operand values
- id_ex_imm  out  32  sign-extended immediate
- id_ex_rs1, id_ex_rs2, id_ex_rd  out  5 each  register indices (for forwarding)
- id_ex_funct3  out  3  funct3
- id_ex_funct7_b5  out  1  instr[30]
- id_ex_opcode  out  7  opcode
- id_ex_alu_src  out  1  1 = immediate operand B
- id_ex_mem_read, id_ex_mem_write, id_ex_reg_write, id_ex_branch, id_ex_jump  out  1 each  control
- id_ex_illegal  out  1  unrecognised opcode

Behaviour:
- Reset: all id_ex_* outputs 0 except id_ex_pc = RESET_PC. All 31 registers x1..x31 cleared to 0.
- Register file:
  - x0 reads 0 always; writes to x0 ignored.
  - Write on posedge when wb_id_we && wb_id_rd != 0.
  - Reads are combinational with write-through: if wb_id_we && wb_id_rd == rsN != 0, read wb_id_wdata.
- Decode (combinational, registered into ID/EX on each non-stall cycle, latency 1):
  - Immediate by opcode:
    - I (0000011, 0010011, 1100111): instr[31:20] sign-extended
    - S (0100011): {instr[31:25], instr[11:7]}
    - B (1100011): {instr[31], instr[7], instr[30:25], instr[11:8], 0}
    - U (0110111, 0010111): {instr[31:12], 12'b0}
    - J (1101111): {instr[31], instr[19:12], instr[20], instr[30:21], 0}
    - R-type: imm = 0
  - Control:
    - reg_write: R, I-ALU, load, LUI, AUIPC, JAL, JALR
    - alu_src: every format except R and B
    - mem_read: load; mem_write: store; branch: B; jump: JAL/JALR
  - Unknown opcode: id_ex_illegal = 1, all other control bits 0, id_ex_valid = 1.
- rs1 usage: all formats except LUI, AUIPC, JAL. rs2 usage: R, S, B only.
- Hazard:
  - Condition: id_ex_valid && id_ex_mem_read && id_ex_rd != 0 && ((uses_rs1 && rs1 == id_ex_rd) || (uses_rs2 && rs2 == id_ex_rd)).
  - stall = hazard && !ex_if_branch_taken.
  - While stall = 1: ID/EX gets a bubble (id_ex_valid = 0, all control bits 0). Fetch holds, so the same instruction is re-decoded next cycle.
  - Stall lasts exactly 1 cycle per load-use pair.
- Flush: ex_if_branch_taken = 1 → next cycle id_ex_valid = 0 and all control bits 0, regardless of hazard. Branch has priority over stall.
- Bubbles: id_ex_pc, indices and data may hold any value, but reg_write, mem_read and mem_write must be 0.
- Reset mid-operation: rst overrides stall and flush. The register file is cleared in the same cycle.

Test Plan:
- Reset: assert rst 2 cycles → id_ex_valid=0, id_ex_pc=0, stall=0; then decode add x4,x3,x0 (0x00018233) → id_ex_rs1_data=0.
- ADDI: instr 0x00500093 at pc 0x10 → next cycle id_ex_valid=1, imm=5, rd=1, rs1=0, reg_write=1, alu_src=1, id_ex_pc=0x10.
- Write-through: wb write x3=0xDEADBEEF in the same cycle 0x00018233 is decoded → id_ex_rs1_data=0xDEADBEEF; write x0=0x1234 → x0 still reads 0.
- Load-use: lw x2,0(x1) (0x0000A103) then add x3,x2,x2 (0x002101B3) → stall=1 for exactly one cycle, one bubble (reg_write=0), then add issues with rs1=rs2=2. Using x5 instead of x2 → no stall.
- Flush priority: load-use hazard present and ex_if_branch_taken=1 in the same cycle → stall=0, next id_ex_valid=0.
- B-immediate: beq x0,x0,-8 (0xFE000CE3) → imm=0xFFFFFFF8, branch=1, reg_write=0, alu_src=0. Opcode 0x0000007F → id_ex_illegal=1, control bits 0.
